// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: owns the PC and runs single-outstanding imem fetches into a one-entry IF/ID slot (option: PC_MISALIGN_FAULT_EN).
// Latency: gnt in cycle 0, rvalid in cycle 1, if_valid in cycle 2; at most one instruction every two cycles.
// Backpressure: no request is issued while the slot is full and if_ready is low; pc and outputs hold.
module pc_fetch_ctrl #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter int              INSTR_BYTES  = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_pc,
    output logic [31:0]     if_instr,
    output logic            if_misaligned
);

`ifdef PC_MISALIGN_FAULT_EN
    localparam bit FAULT_EN = 1'b1;
`else
    localparam bit FAULT_EN = 1'b0;
`endif

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;

    state_t          state;
    logic [XLEN-1:0] pc;
    logic            mis_q;
    logic            halt;
    logic            fault_pend;
    logic [XLEN-1:0] redir_tgt;
    logic            redir_mis;
    logic            gnt_acc;

    always_comb begin
        redir_mis = 1'b0;
        redir_tgt = {redirect_pc[XLEN-1:2], 2'b00};
        if (FAULT_EN) begin
            redir_mis = |redirect_pc[1:0];
            redir_tgt = redirect_pc;
        end
    end

    // A request goes out only if the slot is empty or being drained this cycle.
    assign imem_req      = (state == REQ) && (!if_valid || if_ready);
    assign imem_addr     = pc;
    assign gnt_acc       = imem_req && imem_gnt;
    assign if_misaligned = FAULT_EN ? mis_q : 1'b0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            pc         <= RESET_VECTOR;
            if_valid   <= 1'b0;
            if_pc      <= '0;
            if_instr   <= '0;
            mis_q      <= 1'b0;
            halt       <= 1'b0;
            fault_pend <= 1'b0;
        end else begin
            if (if_valid && if_ready)
                if_valid <= 1'b0;

            if (redirect_valid) begin
                // A grant or an unanswered request still owes a response, so drain it first.
                pc         <= redir_tgt;
                if_valid   <= 1'b0;
                mis_q      <= 1'b0;
                halt       <= redir_mis;
                fault_pend <= redir_mis;
                case (state)
                    IDLE:        state <= redir_mis ? IDLE : REQ;
                    REQ:         state <= gnt_acc ? DRAIN : (redir_mis ? IDLE : REQ);
                    WAIT, DRAIN: state <= imem_rvalid ? (redir_mis ? IDLE : REQ) : DRAIN;
                    default:     state <= IDLE;
                endcase
            end else begin
                case (state)
                    IDLE: begin
                        if (fault_pend) begin
                            if_valid   <= 1'b1;
                            if_pc      <= pc;
                            if_instr   <= NOP;
                            mis_q      <= 1'b1;
                            fault_pend <= 1'b0;
                        end else if (!halt) begin
                            state <= REQ;
                        end
                    end
                    REQ: begin
                        if (gnt_acc)
                            state <= WAIT;
                    end
                    WAIT: begin
                        if (imem_rvalid) begin
                            if_valid <= 1'b1;
                            if_pc    <= pc;
                            if_instr <= imem_rdata;
                            mis_q    <= 1'b0;
                            pc       <= pc + XLEN'(INSTR_BYTES);
                            state    <= REQ;
                        end
                    end
                    DRAIN: begin
                        if (imem_rvalid)
                            state <= halt ? IDLE : REQ;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed scenarios then random traffic against a stream-level model
// (delivered PCs run target, target+4, ... after each redirect; data is a pure function of address).
module tb_pc_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_misaligned;

    pc_fetch_ctrl dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .if_misaligned  (if_misaligned)
    );

    always #5 clk = ~clk;

    int          n_assert = 0;
    int          n_fail   = 0;
    bit          outstanding;
    int          cnt;
    logic [31:0] out_addr;
    int          lat      = 1;
    int          gnt_pct  = 100;
    bit          override_en;
    bit          orphan;
    logic [31:0] exp_pc, fetch_ptr, last_hs_pc, last_gnt_addr;
    bit          hs_seen, gnt_seen;
    int          nhs;
    bit          prev_redir, prev_hold;
    logic [31:0] prev_pc, prev_instr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One clock: drive after the rising edge, act as memory, check and update the model at the falling edge.
    task automatic cycle(input bit redir, input logic [31:0] tgt, input bit rdy);
        @(posedge clk);
        #1;
        redirect_valid = redir;
        redirect_pc    = redir ? tgt : $urandom;
        if_ready       = rdy;
        imem_rvalid    = 1'b0;
        imem_rdata     = $urandom;
        if (outstanding) begin
            cnt--;
            if (cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = override_en ? 32'hDEAD_BEEF : mem_word(out_addr);
            end
        end
        if (orphan) begin
            imem_rvalid = 1'b1;
            imem_rdata  = 32'hDEAD_BEEF;
            orphan      = 1'b0;
        end
        #1;
        imem_gnt = imem_req && ($urandom_range(99) < gnt_pct);
        @(negedge clk);

        if (prev_redir) chk("flush_after_redirect", {31'b0, if_valid}, 32'd0);
        if (prev_hold) begin
            chk("hold_valid", {31'b0, if_valid}, 32'd1);
            chk("hold_pc", if_pc, prev_pc);
            chk("hold_instr", if_instr, prev_instr);
        end
        if (outstanding) chk("single_outstanding", {31'b0, imem_req}, 32'd0);
        if (if_valid && !if_ready) chk("stall_no_req", {31'b0, imem_req}, 32'd0);
`ifndef PC_MISALIGN_FAULT_EN
        chk("misaligned_tied_low", {31'b0, if_misaligned}, 32'd0);
`endif
        if (outstanding && imem_rvalid && cnt == 0) outstanding = 1'b0;

        gnt_seen = imem_gnt;
        if (imem_gnt) begin
            if (!redir) begin
                chk("fetch_addr", imem_addr, fetch_ptr);
                fetch_ptr += 32'd4;
            end
            last_gnt_addr = imem_addr;
            out_addr      = imem_addr;
            outstanding   = 1'b1;
            cnt           = lat;
        end

        hs_seen = if_valid && if_ready && !redir;
        if (hs_seen) begin
            chk("delivered_pc", if_pc, exp_pc);
            chk("delivered_instr", if_instr, mem_word(exp_pc));
            last_hs_pc = if_pc;
            exp_pc += 32'd4;
            nhs++;
        end

        if (redir) begin
            exp_pc    = tgt & 32'hFFFF_FFFC;
            fetch_ptr = tgt & 32'hFFFF_FFFC;
        end
        prev_redir = redir;
        prev_hold  = if_valid && !if_ready && !redir;
        prev_pc    = if_pc;
        prev_instr = if_instr;
    endtask

    task automatic wait_hs(input string tag);
        bit got = 1'b0;
        for (int i = 0; i < 64 && !got; i++) begin
            cycle(1'b0, 32'h0, 1'b1);
            got = hs_seen;
        end
        chk(tag, {31'b0, got}, 32'd1);
    endtask

    task automatic wait_gnt(input string tag);
        bit got = 1'b0;
        for (int i = 0; i < 64 && !got; i++) begin
            cycle(1'b0, 32'h0, 1'b1);
            got = gnt_seen;
        end
        chk(tag, {31'b0, got}, 32'd1);
    endtask

    // Called right after a falling edge; reset may land in the middle of a transaction.
    task automatic do_reset(input bit orphan_after);
        reset_n        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'h0;
        if_ready       = 1'b1;
        outstanding    = 1'b0;
        prev_redir     = 1'b0;
        prev_hold      = 1'b0;
        exp_pc         = 32'h0;
        fetch_ptr      = 32'h0;
        nhs            = 0;
        #1;
        chk("async_reset_valid", {31'b0, if_valid}, 32'd0);
        @(negedge clk);
        chk("reset_req", {31'b0, imem_req}, 32'd0);
        chk("reset_addr", imem_addr, 32'h0);
        chk("reset_valid", {31'b0, if_valid}, 32'd0);
        chk("reset_pc", if_pc, 32'h0);
        chk("reset_instr", if_instr, 32'h0);
        chk("reset_misaligned", {31'b0, if_misaligned}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        orphan  = orphan_after;
    endtask

    initial begin
        override_en = 1'b0;
        orphan      = 1'b0;
        do_reset(1'b0);

        // Minimum latency and free-run throughput: 0, 4, 8, C at one per two cycles.
        cycle(1'b0, 32'h0, 1'b1);
        cycle(1'b0, 32'h0, 1'b1);
        chk("latency_not_yet", {31'b0, if_valid}, 32'd0);
        cycle(1'b0, 32'h0, 1'b1);
        chk("latency_first", {31'b0, if_valid}, 32'd1);
        for (int i = 0; i < 6; i++) cycle(1'b0, 32'h0, 1'b1);
        chk("freerun_count", nhs, 32'd4);
        chk("freerun_last_pc", last_hs_pc, 32'hC);

        // Reset with a request outstanding; its late response must be ignored.
        do_reset(1'b1);
        wait_hs("first_after_reset");
        chk("first_after_reset_pc", last_hs_pc, 32'h0);
        cycle(1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 32'h0, 1'b0);
            chk("stall_req", {31'b0, imem_req}, 32'd0);
            chk("stall_pc", if_pc, 32'h4);
            chk("stall_valid", {31'b0, if_valid}, 32'd1);
        end
        wait_gnt("after_stall_gnt");
        chk("after_stall_addr", last_gnt_addr, 32'h8);

        // Redirect while waiting; stale response arrives three cycles later.
        lat = 4;
        wait_gnt("wait_redirect_gnt");
        override_en = 1'b1;
        cycle(1'b1, 32'h100, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b1);
        override_en = 1'b0;
        lat = 1;
        wait_hs("wait_redirect_hs");
        chk("wait_redirect_pc", last_hs_pc, 32'h100);

        // Redirect in the same cycle as a grant.
        gnt_pct = 0;
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b1);
        chk("req_held_without_gnt", {31'b0, imem_req}, 32'd1);
        gnt_pct = 100;
        cycle(1'b1, 32'h200, 1'b1);
        chk("gnt_with_redirect", {31'b0, gnt_seen}, 32'd1);
        wait_hs("gnt_redirect_hs");
        chk("gnt_redirect_pc", last_hs_pc, 32'h200);

        // Redirect in the same cycle as rvalid.
        lat = 2;
        wait_gnt("rvalid_redirect_gnt");
        cycle(1'b0, 32'h0, 1'b1);
        cycle(1'b1, 32'h80, 1'b1);
        lat = 1;
        wait_hs("rvalid_redirect_hs");
        chk("rvalid_redirect_pc", last_hs_pc, 32'h80);

`ifdef PC_MISALIGN_FAULT_EN
        cycle(1'b1, 32'h102, 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b0, 32'h0, 1'b0);
        chk("fault_valid", {31'b0, if_valid}, 32'd1);
        chk("fault_flag", {31'b0, if_misaligned}, 32'd1);
        chk("fault_pc", if_pc, 32'h102);
        chk("fault_instr", if_instr, 32'h0000_0013);
        chk("fault_no_req", {31'b0, imem_req}, 32'd0);
        cycle(1'b1, 32'h300, 1'b1);
        wait_hs("fault_recover_hs");
        chk("fault_recover_pc", last_hs_pc, 32'h300);
`else
        cycle(1'b1, 32'h102, 1'b1);
        wait_gnt("misaligned_gnt");
        chk("misaligned_fetch_addr", last_gnt_addr, 32'h100);
        wait_hs("misaligned_hs");
        chk("misaligned_pc", last_hs_pc, 32'h100);
`endif

        // Random traffic against the stream model.
        nhs = 0;
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] tgt;
            bit          r;
            lat     = $urandom_range(1, 3);
            gnt_pct = 60;
            r       = ($urandom_range(99) < 4);
            tgt     = $urandom_range(0, 1023);
`ifdef PC_MISALIGN_FAULT_EN
            tgt     = tgt & 32'hFFFF_FFFC;
`endif
            cycle(r, tgt, $urandom_range(99) < 70);
        end
        chk("random_progress", {31'b0, (nhs > 50)}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
